shader_spi_loader: RTL and testbench

FPGA-side SPI master that feeds a shader program into tt_um_tiny_shader_mole99 through its SPI pins (uio_in[0] CS_N, uio_in[1] SCLK, uio_in[3] MOSI, uio_out[2] MISO).
- On start, reads NUM_BYTES bytes from a synchronous program ROM.
- Sends one SPI write transaction: one command byte, then the program bytes.
- Lives in the board top next to the shader instance, clocked by the 25.125 MHz PLL clock.

---
 rtl/shader_spi_loader.sv | 117 +++++++++++
 tb/tb_shader_spi_loader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/shader_spi_loader.sv
// shader_spi_loader: SPI mode-0 master streaming a command byte plus a ROM-held shader program into the shader core.
module shader_spi_loader #(
  parameter int NUM_BYTES = 32,
  parameter int CLK_DIV = 4,
  parameter logic [7:0] CMD_WRITE = 8'h00,
  parameter bit AUTO_START = 1'b1,
  localparam int AW = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1,
  localparam int DW = $clog2(CLK_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  output logic [AW-1:0] rom_addr_o,
  input  logic [7:0]    rom_data_i,
  output logic          spi_cs_n_o,
  output logic          spi_sclk_o,
  output logic          spi_mosi_o,
  input  logic          spi_miso_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [7:0]    last_rx_o
);
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, FETCH, CS_HOLD, DONE} state_t;
  localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_GAP = DW'(CLK_DIV - 2);
  localparam logic [AW-1:0] ADDR_END = AW'(NUM_BYTES - 1);
  state_t state;
  logic [DW-1:0] div;
  logic [2:0] bit_cnt;
  logic [8:0] byte_cnt;
  logic [7:0] tx_sr, rx_sr;
  logic auto_pend, cooled;
  // cooled gates new frames so CS_N stays high at least CLK_DIV cycles after DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      div <= '0;
      bit_cnt <= '0;
      byte_cnt <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      auto_pend <= AUTO_START;
      cooled <= 1'b1;
      rom_addr_o <= '0;
      spi_cs_n_o <= 1'b1;
      spi_sclk_o <= 1'b0;
      spi_mosi_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      last_rx_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!cooled) begin
            div <= div == DIV_GAP ? '0 : div + DW'(1);
            cooled <= div == DIV_GAP;
          end else if (start_i || auto_pend) begin
            state <= CS_SETUP;
            auto_pend <= 1'b0;
            spi_cs_n_o <= 1'b0;
            busy_o <= 1'b1;
            tx_sr <= CMD_WRITE;
            spi_mosi_o <= CMD_WRITE[7];
            bit_cnt <= '0;
            byte_cnt <= '0;
            div <= '0;
          end
        end
        CS_SETUP: begin
          rom_addr_o <= '0;
          div <= div == DIV_END ? '0 : div + DW'(1);
          state <= div == DIV_END ? SHIFT : CS_SETUP;
        end
        SHIFT: begin
          if (div != DIV_END) div <= div + DW'(1);
          else begin
            div <= '0;
            spi_sclk_o <= ~spi_sclk_o;
            if (!spi_sclk_o) rx_sr <= {rx_sr[6:0], spi_miso_i};
            else begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                last_rx_o <= rx_sr;
                byte_cnt <= byte_cnt + 9'd1;
                state <= byte_cnt < 9'(NUM_BYTES) ? FETCH : CS_HOLD;
              end else begin
                tx_sr <= {tx_sr[6:0], 1'b0};
                spi_mosi_o <= tx_sr[6];
              end
            end
          end
        end
        FETCH: begin
          tx_sr <= rom_data_i;
          spi_mosi_o <= rom_data_i[7];
          rom_addr_o <= rom_addr_o == ADDR_END ? rom_addr_o : rom_addr_o + AW'(1);
          div <= '0;
          state <= SHIFT;
        end
        CS_HOLD: begin
          div <= div == DIV_END ? '0 : div + DW'(1);
          spi_cs_n_o <= div == DIV_END;
          done_o <= div == DIV_END;
          state <= div == DIV_END ? DONE : CS_HOLD;
        end
        DONE: begin
          busy_o <= 1'b0;
          rom_addr_o <= '0;
          cooled <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shader_spi_loader.sv
// tb_shader_spi_loader: scoreboard bench with two loader instances (manual start / auto start) and SPI slave monitors.
module tb_shader_spi_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  logic [7:0] rom [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
  logic [7:0] frame [5] = '{8'h00, 8'hA5, 8'h3C, 8'hFF, 8'h01};
  logic [7:0] qa[$], qb[$];
  logic rst_a, rst_b, a_start, b_start, a_miso, b_miso;
  logic [1:0] a_addr, b_addr;
  logic [7:0] a_data, b_data, a_last_rx, b_last_rx;
  logic a_cs_n, a_sclk, a_mosi, a_busy, a_done;
  logic b_cs_n, b_sclk, b_mosi, b_busy, b_done;
  int a_rises = 0, a_cs_falls = 0, a_cs_rises = 0, b_cs_falls = 0;
  always @(posedge clk) a_data <= rom[a_addr];
  always @(posedge clk) b_data <= rom[b_addr];
  shader_spi_loader #(.NUM_BYTES(4), .CLK_DIV(2), .CMD_WRITE(8'h00), .AUTO_START(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_a), .start_i(a_start), .rom_addr_o(a_addr), .rom_data_i(a_data),
    .spi_cs_n_o(a_cs_n), .spi_sclk_o(a_sclk), .spi_mosi_o(a_mosi), .spi_miso_i(a_miso),
    .busy_o(a_busy), .done_o(a_done), .last_rx_o(a_last_rx));
  shader_spi_loader #(.NUM_BYTES(4), .CLK_DIV(4), .CMD_WRITE(8'h00), .AUTO_START(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_b), .start_i(b_start), .rom_addr_o(b_addr), .rom_data_i(b_data),
    .spi_cs_n_o(b_cs_n), .spi_sclk_o(b_sclk), .spi_mosi_o(b_mosi), .spi_miso_i(b_miso),
    .busy_o(b_busy), .done_o(b_done), .last_rx_o(b_last_rx));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // slave A: collects bytes and counts edges
  initial begin
    logic prev_s, prev_cs;
    logic [7:0] sh;
    int nb;
    prev_s = 1'b0; prev_cs = 1'b1; sh = '0; nb = 0;
    forever begin
      @(negedge clk);
      if (a_cs_n && !prev_cs) a_cs_rises++;
      if (!a_cs_n && prev_cs) a_cs_falls++;
      if (a_cs_n) nb = 0;
      else if (a_sclk && !prev_s) begin
        a_rises++;
        sh = {sh[6:0], a_mosi};
        nb++;
        if (nb == 8) begin
          nb = 0;
          chk("a_byte_expected", qa.size() != 0, 1);
          if (qa.size() != 0) chk("a_byte", sh, qa.pop_front());
        end
      end
      prev_s = a_sclk;
      prev_cs = a_cs_n;
    end
  end
  // slave B: collects bytes, drives MISO, checks SCLK phase lengths and MOSI stability
  initial begin
    logic prev_s, prev_cs, prev_mosi;
    logic [7:0] sh, pat;
    int nb, nbyte, run;
    prev_s = 1'b0; prev_cs = 1'b1; prev_mosi = 1'b0; sh = '0; nb = 0; nbyte = 0; run = 0;
    b_miso = 1'b0;
    forever begin
      @(negedge clk);
      if (b_cs_n) begin
        nb = 0;
        nbyte = 0;
      end else if (prev_cs) begin
        b_cs_falls++;
        run = 1;
        nb = 0;
        nbyte = 0;
      end else if (b_sclk && !prev_s) begin
        if (nb == 0 && nbyte == 0) chk("b_setup_low", run >= 4 && run <= 8, 1);
        else if (nb == 0) chk("b_gap_low", run, 5);
        else chk("b_low", run, 4);
        chk("b_mosi_stable", b_mosi, prev_mosi);
        sh = {sh[6:0], b_mosi};
        nb++;
        if (nb == 8) begin
          nb = 0;
          nbyte++;
          chk("b_byte_expected", qb.size() != 0, 1);
          if (qb.size() != 0) chk("b_byte", sh, qb.pop_front());
        end
        run = 1;
      end else if (!b_sclk && prev_s) begin
        chk("b_high", run, 4);
        run = 1;
      end else run++;
      if (!b_cs_n && !b_sclk) begin
        pat = nbyte == 4 ? 8'h5A : 8'hC3;
        b_miso = pat[7 - nb];
      end
      prev_s = b_sclk;
      prev_cs = b_cs_n;
      prev_mosi = b_mosi;
    end
  end
  initial begin
    rst_a = 1'b0; rst_b = 1'b0; a_start = 1'b0; b_start = 1'b0; a_miso = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_rst_cs_n", a_cs_n, 1);
    chk("a_rst_sclk", a_sclk, 0);
    chk("a_rst_mosi", a_mosi, 0);
    chk("a_rst_busy", a_busy, 0);
    chk("a_rst_done", a_done, 0);
    chk("a_rst_last_rx", a_last_rx, 0);
    chk("a_rst_addr", a_addr, 0);
    chk("b_rst_cs_n", b_cs_n, 1);
    chk("b_rst_sclk", b_sclk, 0);
    chk("b_rst_busy", b_busy, 0);
    for (int i = 0; i < 5; i++) begin
      qa.push_back(frame[i]);
      qb.push_back(frame[i]);
    end
    rst_a = 1'b1; rst_b = 1'b1;
    fork
      begin
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("a_busy_after_start", a_busy, 1);
        for (int i = 0; i < 1000 && !a_done; i++) @(negedge clk);
        chk("a_done_seen", a_done, 1);
        @(negedge clk);
        chk("a_done_width", a_done, 0);
        chk("a_busy_after_done", a_busy, 0);
        chk("a_sclk_rises", a_rises, 40);
        chk("a_cs_falls", a_cs_falls, 1);
        chk("a_cs_rises", a_cs_rises, 1);
        chk("a_bytes_left", qa.size(), 0);
        chk("a_addr_after_done", a_addr, 0);
      end
      begin
        for (int i = 0; i < 2 && b_cs_n; i++) @(negedge clk);
        chk("b_auto_start_cs", b_cs_n, 0);
        chk("b_auto_start_busy", b_busy, 1);
        repeat (100) @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < 1000 && !b_done; i++) @(negedge clk);
        chk("b_done_seen", b_done, 1);
        chk("b_last_rx", b_last_rx, 8'h5A);
        @(negedge clk);
        chk("b_done_width", b_done, 0);
        chk("b_busy_after_done", b_busy, 0);
        chk("b_bytes_left", qb.size(), 0);
        repeat (300) @(negedge clk);
        chk("b_no_second_frame", b_cs_falls, 1);
        chk("b_idle_cs_n", b_cs_n, 1);
        for (int i = 0; i < 5; i++) qb.push_back(frame[i]);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        repeat (150) @(negedge clk);
        chk("b_bytes_before_reset", qb.size(), 3);
        #1 rst_b = 1'b0;
        #1;
        chk("b_async_cs_n", b_cs_n, 1);
        chk("b_async_sclk", b_sclk, 0);
        chk("b_async_busy", b_busy, 0);
        chk("b_async_last_rx", b_last_rx, 0);
        qb.delete();
        for (int i = 0; i < 5; i++) qb.push_back(frame[i]);
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 1000 && !b_done; i++) @(negedge clk);
        chk("b_restart_done_seen", b_done, 1);
        chk("b_restart_last_rx", b_last_rx, 8'h5A);
        @(negedge clk);
        chk("b_restart_bytes_left", qb.size(), 0);
        chk("b_frames_total", b_cs_falls, 3);
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
